// File: rtl/masked_array_pkg.sv
// Shared types and helpers for the masked, clearable register array.
// Included by the clear sequencer and the array top.
package masked_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clear_state_e;

  function automatic int calc_num_gran(input int width, input int gran_width);
    return width / gran_width;
  endfunction

endpackage

// File: rtl/array_clear_seq.sv
// Clear-all sequencer: walks a pointer over every set, one set per cycle,
// then pulses clear_done. Requests arriving outside IDLE are ignored.
module array_clear_seq
  import masked_array_pkg::*;
#(
  parameter int s_index  = 3,
  parameter int num_sets = 2 ** s_index
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_req,
  output logic               busy,
  output logic               clear_done,
  output logic               clr_we,
  output logic [s_index-1:0] clr_idx,
  output clear_state_e       state
);

  localparam logic [s_index-1:0] last_idx = s_index'(num_sets - 1);

  logic [s_index-1:0] ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          // The entry at ptr is zeroed by the top on this same edge.
          if (ptr == last_idx) begin
            state      <= DONE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          clear_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we  = busy;
  assign clr_idx = ptr;

endmodule

// File: rtl/masked_clear_array.sv
// Flop-based register array with per-granule write masks, optional registered
// read, and a multi-cycle clear-all sequence for flush/invalidate.
module masked_clear_array
  import masked_array_pkg::*;
#(
  parameter int s_index    = 3,
  parameter int num_sets   = 2 ** s_index,
  parameter int width      = 32,
  parameter int gran_width = 8,
  localparam int num_gran  = calc_num_gran(width, gran_width),
  parameter int reg_read   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic                load,
  input  logic [s_index-1:0]  index,
  input  logic [num_gran-1:0] wmask,
  input  logic [width-1:0]    datain,
  input  logic                clear_req,
  output logic [width-1:0]    dataout,
  output logic                busy,
  output logic                clear_done
);

  if ((width % gran_width) != 0) begin : g_bad_gran
    $error("masked_clear_array: gran_width must divide width");
  end

  (* ramstyle = "logic" *) logic [width-1:0] data [num_sets];

  logic               clr_we;
  logic [s_index-1:0] clr_idx;
  clear_state_e       clr_state;
  logic               in_clear;
  logic               index_ok;
  logic [width-1:0]   rd_q;

  array_clear_seq #(
    .s_index (s_index),
    .num_sets(num_sets)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clear_done(clear_done),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx),
    .state     (clr_state)
  );

  assign in_clear = (clr_state == CLEAR);
  assign index_ok = (32'(index) < num_sets);

  // The sequencer owns the write port while clearing; user loads are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < num_sets; i++) data[i] <= '0;
    end else if (clr_we) begin
      data[clr_idx] <= '0;
    end else if (load && index_ok) begin
      for (int g = 0; g < num_gran; g++) begin
        if (wmask[g]) data[index][g*gran_width +: gran_width] <= datain[g*gran_width +: gran_width];
      end
    end
  end

  // Registered read samples pre-write contents (read-old-data).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if ((reg_read != 0) && read) begin
      rd_q <= (in_clear || !index_ok) ? '0 : data[index];
    end
  end

  always_comb begin
    dataout = '0;
    if (!in_clear) begin
      if (reg_read != 0) dataout = rd_q;
      else if (index_ok) dataout = data[index];
    end
  end

endmodule

// File: tb/tb_masked_clear_array.sv
// Bench for masked_clear_array: one combinational-read and one registered-read
// instance share stimulus; expectations go through a queue-based scoreboard.
module tb_masked_clear_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        load = 1'b0;
  logic [2:0]  index = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] datain = '0;
  logic        clear_req = 1'b0;
  logic [31:0] dout_c, dout_r;
  logic        busy_c, busy_r, done_c, done_r;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        load;
    logic [2:0]  index;
    logic [3:0]  wmask;
    logic [31:0] datain;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  masked_clear_array #(.s_index(3), .width(32), .gran_width(8), .reg_read(0)) u_comb (
    .clk(clk), .rst(rst), .read(read), .load(load), .index(index), .wmask(wmask),
    .datain(datain), .clear_req(clear_req), .dataout(dout_c), .busy(busy_c), .clear_done(done_c)
  );

  masked_clear_array #(.s_index(3), .width(32), .gran_width(8), .reg_read(1)) u_reg (
    .clk(clk), .rst(rst), .read(read), .load(load), .index(index), .wmask(wmask),
    .datain(datain), .clear_req(clear_req), .dataout(dout_r), .busy(busy_r), .clear_done(done_r)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=0x%08h expected=<empty queue>", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  task automatic write(input logic [2:0] idx, input logic [3:0] m, input logic [31:0] d);
    load = 1'b1; index = idx; wmask = m; datain = d;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, done_k;
    logic [2:0]  ridx;
    logic [31:0] rdat;

    vecs[0] = '{1'b1, 3'd2, 4'b1111, 32'hAABBCCDD, 32'hAABBCCDD};
    vecs[1] = '{1'b1, 3'd2, 4'b0101, 32'h11223344, 32'hAA22CC44};
    vecs[2] = '{1'b1, 3'd2, 4'b0000, 32'hFFFFFFFF, 32'hAA22CC44};
    vecs[3] = '{1'b1, 3'd4, 4'b1000, 32'h12345678, 32'h12000000};
    vecs[4] = '{1'b1, 3'd4, 4'b0010, 32'h9ABCDEF0, 32'h1200DE00};
    vecs[5] = '{1'b1, 3'd2, 4'b1010, 32'h55667788, 32'h55227744};

    // Reset, then combinational read of a zeroed entry.
    tick(); tick();
    rst = 1'b0;
    index = 3'd5;
    #1;
    check("reset_dout_comb", dout_c, 32'h0);
    check("reset_dout_reg", dout_r, 32'h0);
    check("reset_busy", {31'b0, busy_c}, 32'h0);
    check("reset_done", {31'b0, done_c}, 32'h0);

    // Masked writes, visible in the cycle after the edge.
    for (int i = 0; i < 6; i++) begin
      load = vecs[i].load; index = vecs[i].index; wmask = vecs[i].wmask; datain = vecs[i].datain;
      exp_q.push_back(vecs[i].exp);
      tick();
      load = 1'b0;
      #1;
      sb_check($sformatf("vec%0d_dout_comb", i), dout_c);
    end

    // Random full-width writes to entries 0,1,3,5.
    for (int i = 0; i < 4; i++) begin
      ridx = (i == 0) ? 3'd0 : (i == 1) ? 3'd1 : (i == 2) ? 3'd3 : 3'd5;
      rdat = $urandom_range(32'hFFFF, 0) ^ (32'h1 << $urandom_range(31, 0));
      exp_q.push_back(rdat);
      write(ridx, 4'b1111, rdat);
      sb_check("rand_write_comb", dout_c);
    end

    // Registered read returns old data when written in the same cycle.
    write(3'd3, 4'b1111, 32'h1);
    load = 1'b1; index = 3'd3; wmask = 4'b1111; datain = 32'h2; read = 1'b1;
    exp_q.push_back(32'h1);
    tick();
    load = 1'b0;
    sb_check("reg_read_old", dout_r);
    check("comb_sees_new", dout_c, 32'h2);
    exp_q.push_back(32'h2);
    tick();
    sb_check("reg_read_new", dout_r);
    read = 1'b0; index = 3'd0;
    exp_q.push_back(32'h2);
    tick();
    sb_check("reg_read_hold", dout_r);

    // Fill everything, then run a clear with injected loads and a repeat request.
    for (int i = 0; i < 8; i++) write(3'(i), 4'b1111, 32'hFFFFFFFF);
    read = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_k = -1;
    for (int k = 0; k < 20; k++) begin
      if (busy_c) begin
        busy_cnt++;
        check("busy_dout_comb", dout_c, 32'h0);
        check("busy_dout_reg", dout_r, 32'h0);
      end
      load = 1'b0; clear_req = 1'b0;
      if (done_c) begin
        done_cnt++;
        done_k = k;
        load = 1'b1; index = 3'd6; wmask = 4'b1111; datain = 32'h0000ABCD;
      end
      if (k == 3) clear_req = 1'b1;
      if (k == 5) begin load = 1'b1; index = 3'd0; wmask = 4'b1111; datain = 32'hDEADBEEF; end
      if (k == 6) begin load = 1'b1; index = 3'd7; wmask = 4'b1111; datain = 32'hDEADBEEF; end
      tick();
    end
    load = 1'b0; read = 1'b0;
    check("clear_busy_cycles", 32'(busy_cnt), 32'd8);
    check("clear_done_count", 32'(done_cnt), 32'd1);
    check("clear_done_cycle", 32'(done_k), 32'd8);
    for (int i = 0; i < 8; i++) begin
      index = 3'(i);
      exp_q.push_back((i == 6) ? 32'h0000ABCD : 32'h0);
      #1;
      sb_check($sformatf("after_clear_idx%0d", i), dout_c);
    end

    // Reset during the clear: immediate idle, no done pulse, entries zero.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pre_reset_busy", {31'b0, busy_c}, 32'h1);
    rst = 1'b1;
    #1;
    check("midclear_rst_busy", {31'b0, busy_c}, 32'h0);
    check("midclear_rst_busy_reg", {31'b0, busy_r}, 32'h0);
    check("midclear_rst_done", {31'b0, done_c}, 32'h0);
    check("midclear_rst_dout_reg", dout_r, 32'h0);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_c || done_r) done_cnt++;
      tick();
    end
    check("midclear_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 8; i++) begin
      index = 3'(i);
      exp_q.push_back(32'h0);
      #1;
      sb_check($sformatf("after_rst_idx%0d", i), dout_c);
    end
    write(3'd1, 4'b1111, 32'h5);
    index = 3'd1;
    #1;
    check("post_rst_write_comb", dout_c, 32'h5);
    read = 1'b1;
    tick();
    read = 1'b0;
    check("post_rst_write_reg", dout_r, 32'h5);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
